// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66:64 TX gearbox: repacks {data, sync header} blocks into gap-free 64-bit PMA words.
// Latency: a block's first bit is on data_out the cycle after acceptance, once 64 bits are buffered.
// Backpressure: in_ready is low one cycle in 33 at full load and depends on registered state only.
module eth_phy_10g_tx_gearbox #(
  parameter int HDR_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  hdr_in,
  input  logic [63:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] data_out,
  output logic        out_valid,
  output logic        hdr_err,
  output logic        underrun
);

  logic [129:0] sbuf;
  logic [7:0]   cnt;
  logic         started;

  logic         emit;
  logic [7:0]   r;
  logic         accept;
  logic         hdr_bad;
  logic [129:0] shifted;
  logic [129:0] blk_ext;
  logic [129:0] sbuf_nxt;
  logic [7:0]   cnt_nxt;

  // Bits above cnt are always zero, so a new block can be OR-ed in at position r.
  always_comb begin
    emit     = (cnt >= 8'd64);
    r        = emit ? (cnt - 8'd64) : cnt;
    in_ready = (r < 8'd64);
    accept   = in_valid && in_ready;
    shifted  = emit ? {64'd0, sbuf[129:64]} : sbuf;
    blk_ext  = {64'd0, data_in, hdr_in} << r;
    sbuf_nxt = accept ? (shifted | blk_ext) : shifted;
    cnt_nxt  = accept ? (r + 8'd66) : r;
    hdr_bad  = (HDR_CHECK != 0) && (hdr_in[0] == hdr_in[1]);
  end

  assign data_out  = sbuf[63:0];
  assign out_valid = emit;
  assign underrun  = started && !emit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbuf    <= '0;
      cnt     <= '0;
      started <= 1'b0;
      hdr_err <= 1'b0;
    end else begin
      sbuf    <= sbuf_nxt;
      cnt     <= cnt_nxt;
      started <= started || emit;
      hdr_err <= accept && hdr_bad;
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Random and directed checks of the 66:64 TX gearbox against a bit-queue stream model.
module tb_eth_phy_10g_tx_gearbox;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  hdr_in = 2'b01;
  logic [63:0] data_in = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, out_valid, hdr_err, underrun;
  logic [63:0] data_out;
  logic        nc_in_ready, nc_out_valid, nc_hdr_err, nc_underrun;
  logic [63:0] nc_data_out;

  always #5 clk = ~clk;

  eth_phy_10g_tx_gearbox #(.HDR_CHECK(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .hdr_in(hdr_in), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .out_valid(out_valid), .hdr_err(hdr_err), .underrun(underrun)
  );

  eth_phy_10g_tx_gearbox #(.HDR_CHECK(0)) u_nochk (
    .clk(clk), .reset_n(reset_n), .hdr_in(hdr_in), .data_in(data_in),
    .in_valid(in_valid), .in_ready(nc_in_ready), .data_out(nc_data_out),
    .out_valid(nc_out_valid), .hdr_err(nc_hdr_err), .underrun(nc_underrun)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: the serial stream as a queue of bits, earliest first.
  bit          q[$];
  bit          started = 1'b0;
  bit          exp_herr = 1'b0;
  logic [63:0] wlog[$];
  int          lowlog[$];
  int          cyc = 0;
  int          nv_cnt = 0;
  int          ur_cnt = 0;
  int          herr_cnt = 0;
  int          nc_herr_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d, output bit acc);
    int          len;
    bit          emit;
    int          r;
    logic [63:0] w;
    in_valid = v;
    hdr_in   = h;
    data_in  = d;
    len  = q.size();
    emit = (len >= 64);
    r    = emit ? len - 64 : len;
    chk("out_valid", 64'(out_valid), 64'(emit));
    chk("in_ready", 64'(in_ready), 64'(r < 64));
    chk("underrun", 64'(underrun), 64'(started && !emit));
    chk("hdr_err", 64'(hdr_err), 64'(exp_herr));
    chk("hdr_err_nochk", 64'(nc_hdr_err), 64'd0);
    if (!in_ready) lowlog.push_back(cyc);
    if (started && !out_valid) nv_cnt++;
    if (underrun) ur_cnt++;
    if (hdr_err) herr_cnt++;
    if (nc_hdr_err) nc_herr_cnt++;
    if (emit) begin
      w = '0;
      for (int i = 0; i < 64; i++) w[i] = q.pop_front();
      chk("data_out", data_out, w);
      wlog.push_back(data_out);
      started = 1'b1;
    end
    acc      = v && (r < 64);
    exp_herr = acc && (h == 2'b00 || h == 2'b11);
    if (acc) begin
      q.push_back(h[0]);
      q.push_back(h[1]);
      for (int i = 0; i < 64; i++) q.push_back(d[i]);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] h, input logic [63:0] d);
    bit acc = 1'b0;
    for (int k = 0; k < 4 && !acc; k++) step(1'b1, h, d, acc);
    chk("send_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic run_blocks(input int n, input int duty, input int hmode);
    int          done = 0;
    int          guard = 0;
    bit          have = 1'b0;
    bit          acc;
    logic [1:0]  h = 2'b01;
    logic [63:0] d = '0;
    while (done < n && guard < n * 4 + 100) begin
      if (!have) begin
        have = ($urandom_range(99) < duty);
        h = (hmode == 0) ? (($urandom_range(1) == 1) ? 2'b01 : 2'b10) : 2'($urandom);
        d = {$urandom, $urandom};
      end
      step(have, h, d, acc);
      if (acc) begin
        have = 1'b0;
        done++;
      end
      guard++;
    end
    chk("run_blocks_timeout", 64'(done), 64'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"}, data_out, 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_hdr_err"}, 64'(hdr_err), 64'd0);
    chk({tag, "_underrun"}, 64'(underrun), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #2;
    check_reset_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    wlog.delete();
    started  = 1'b0;
    exp_herr = 1'b0;
  endtask

  initial begin
    bit acc;

    do_reset("rst0");

    // Two directed blocks followed by 328 more, valid held high throughout.
    lowlog.delete();
    cyc = 0;
    nv_cnt = 0;
    send(2'b01, 64'h0);
    send(2'b01, 64'h1);
    run_blocks(328, 100, 0);
    chk("first_word", wlog[0], 64'h1);
    chk("second_word_lsbs", 64'(wlog[1][4:0]), 64'(5'b10100));
    chk("rdy_low_count", 64'(lowlog.size()), 64'd10);
    if (lowlog.size() > 0) chk("rdy_low_first", 64'(lowlog[0]), 64'd32);
    for (int i = 1; i < lowlog.size(); i++)
      chk("rdy_low_gap", 64'(lowlog[i] - lowlog[i-1]), 64'd33);
    chk("out_valid_gaps", 64'(nv_cnt), 64'd0);

    // Starvation mid-stream.
    run_blocks(20, 100, 0);
    nv_cnt = 0;
    ur_cnt = 0;
    for (int k = 0; k < 3; k++) step(1'b0, 2'b01, 64'd0, acc);
    run_blocks(20, 100, 0);
    chk("starve_underrun_match", 64'(ur_cnt), 64'(nv_cnt));
    chk("starve_seen", 64'(ur_cnt >= 2), 64'd1);

    // One bad header in a run of good ones.
    herr_cnt = 0;
    nc_herr_cnt = 0;
    for (int k = 0; k < 10; k++) send(2'b10, {$urandom, $urandom});
    send(2'b11, {$urandom, $urandom});
    for (int k = 0; k < 10; k++) send(2'b10, {$urandom, $urandom});
    chk("hdr_err_pulses", 64'(herr_cnt), 64'd1);
    chk("hdr_err_nochk_pulses", 64'(nc_herr_cnt), 64'd0);

    // Reset while 40 bits are buffered.
    do_reset("rst1");
    for (int k = 0; k < 200 && q.size() != 104; k++) step(1'b1, 2'b01, {$urandom, $urandom}, acc);
    chk("reach_cnt104", 64'(q.size()), 64'd104);
    step(1'b0, 2'b01, 64'd0, acc);
    chk("reach_cnt40", 64'(q.size()), 64'd40);
    do_reset("rst_mid");
    send(2'b10, {$urandom, $urandom});
    step(1'b0, 2'b01, 64'd0, acc);
    chk("post_reset_words", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("post_reset_hdr", 64'(wlog[0][1:0]), 64'(2'b10));

    // Long random run with 50% offer rate and arbitrary headers.
    run_blocks(10000, 50, 1);
    for (int k = 0; k < 4; k++) step(1'b0, 2'b01, 64'd0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
